riscv_decode_queue: RTL and testbench

//  Parametrised multi-lane decode buffer between fetch and issue in the dual-issue core.

---
 rtl/riscv_decode_queue.sv | 183 ++++++++++++++++++
 tb/tb_riscv_decode_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_queue.sv
// Multi-lane decode buffer between fetch and issue, with a per-lane instruction decoder.
// Optional same-cycle forwarding when empty: define DECODE_QUEUE_BYPASS_EN.

module riscv_decoder (
    input  logic        valid,
    input  logic        fault_in,
    input  logic        en_muldiv,
    input  logic [31:0] instr,
    output logic [7:0]  flags
);
    // Flag layout {invalid,rd_valid,csr,div,mul,branch,lsu,exec}; all zero when not valid.
    always_comb begin
        flags = 8'h00;
        if (!valid) begin
            flags = 8'h00;
        end else if (fault_in) begin
            flags = 8'h80;
        end else begin
            case (instr[6:0])
                7'b0110111, 7'b0010111, 7'b0010011: flags = 8'h41;
                7'b0110011: begin
                    if (instr[31:25] == 7'b0000001) begin
                        if (en_muldiv) begin
                            flags = instr[14] ? 8'h50 : 8'h48;
                        end else begin
                            flags = 8'h80;
                        end
                    end else if ((instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000)) begin
                        flags = 8'h41;
                    end else begin
                        flags = 8'h80;
                    end
                end
                7'b1101111, 7'b1100111: flags = 8'h44;
                7'b1100011:             flags = 8'h04;
                7'b0000011:             flags = 8'h42;
                7'b0100011:             flags = 8'h02;
                7'b1110011:             flags = (instr[14:12] != 3'b000) ? 8'h60 : 8'h01;
                7'b0001111:             flags = 8'h01;
                default:                flags = 8'h80;
            endcase
        end
    end
endmodule

module riscv_decode_queue #(
    parameter int LANES          = 2,
    parameter int DEPTH          = 4,
    parameter int SUPPORT_MULDIV = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          in_valid,
    input  logic [32*LANES-1:0]       in_instr,
    input  logic [32*LANES-1:0]       in_pc,
    input  logic [LANES-1:0]          in_fault_fetch,
    input  logic [LANES-1:0]          in_fault_page,
    output logic                      in_accept,
    input  logic                      squash,
    output logic [LANES-1:0]          out_valid,
    output logic [32*LANES-1:0]       out_instr,
    output logic [32*LANES-1:0]       out_pc,
    output logic [LANES-1:0]          out_fault_fetch,
    output logic [LANES-1:0]          out_fault_page,
    output logic [8*LANES-1:0]        out_flags,
    input  logic [LANES-1:0]          out_accept,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] ACC_LIMIT = CW'(DEPTH - LANES);
    localparam logic MULDIV_EN = (SUPPORT_MULDIV != 0);

    function automatic logic [CW-1:0] lead_ones(input logic [LANES-1:0] m);
        logic [CW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            if (run && m[k]) begin
                n = n + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    logic [PW-1:0] rd_ptr_r, wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   instr_mem_r [DEPTH];
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [DEPTH-1:0] ff_mem_r, fp_mem_r;

    logic [CW-1:0] push_n_s, push_eff_s, pop_n_s, skip_s;
    logic          accept_s, bypass_s;
    logic [LANES-1:0] wr_en_s;
    logic [PW-1:0]    wr_idx_s [LANES];
    logic [PW-1:0]    rd_idx_s [LANES];

    // Admission, lane presentation (storage or forwarded input) and pop/write bookkeeping.
    always_comb begin
        push_n_s   = lead_ones(in_valid);
        accept_s   = !rst_n && !squash && (count_r <= ACC_LIMIT);
        push_eff_s = accept_s ? push_n_s : '0;
`ifdef DECODE_QUEUE_BYPASS_EN
        bypass_s   = (count_r == '0) && !squash && !rst_n;
`else
        bypass_s   = 1'b0;
`endif
        out_valid       = '0;
        out_instr       = '0;
        out_pc          = '0;
        out_fault_fetch = '0;
        out_fault_page  = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_idx_s[k] = rd_ptr_r + PW'(k);
            if (bypass_s) begin
                out_valid[k]         = (CW'(k) < push_n_s);
                out_fault_fetch[k]   = in_fault_fetch[k];
                out_fault_page[k]    = in_fault_page[k];
                out_pc[32*k +: 32]   = in_pc[32*k +: 32];
                out_instr[32*k +: 32] = (in_fault_fetch[k] | in_fault_page[k]) ? 32'h0 : in_instr[32*k +: 32];
            end else begin
                out_valid[k]         = (count_r > CW'(k));
                out_fault_fetch[k]   = ff_mem_r[rd_idx_s[k]];
                out_fault_page[k]    = fp_mem_r[rd_idx_s[k]];
                out_pc[32*k +: 32]   = pc_mem_r[rd_idx_s[k]];
                out_instr[32*k +: 32] = instr_mem_r[rd_idx_s[k]];
            end
        end
        pop_n_s = lead_ones(out_accept & out_valid);
        skip_s  = bypass_s ? pop_n_s : '0;
        for (int k = 0; k < LANES; k++) begin
            wr_en_s[k]  = accept_s && (CW'(k) < push_n_s) && (CW'(k) >= skip_s);
            wr_idx_s[k] = wr_ptr_r + PW'(k) - PW'(skip_s);
        end
    end

    // Queue state: async clear, squash flush, else concurrent push and pop.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            ff_mem_r <= '0;
            fp_mem_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= 32'h0;
                pc_mem_r[i]    <= 32'h0;
            end
        end else if (squash) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_en_s[k]) begin
                    instr_mem_r[wr_idx_s[k]] <= (in_fault_fetch[k] | in_fault_page[k]) ? 32'h0 : in_instr[32*k +: 32];
                    pc_mem_r[wr_idx_s[k]]    <= in_pc[32*k +: 32];
                    ff_mem_r[wr_idx_s[k]]    <= in_fault_fetch[k];
                    fp_mem_r[wr_idx_s[k]]    <= in_fault_page[k];
                end
            end
            wr_ptr_r <= wr_ptr_r + PW'(push_eff_s - skip_s);
            rd_ptr_r <= rd_ptr_r + (bypass_s ? PW'(0) : PW'(pop_n_s));
            count_r  <= count_r + push_eff_s - pop_n_s;
        end
    end

    assign in_accept = accept_s;
    assign occupancy = count_r;

    for (genvar k = 0; k < LANES; k++) begin : g_dec
        riscv_decoder u_dec (
            .valid     (out_valid[k]),
            .fault_in  (out_fault_page[k] | out_fault_fetch[k]),
            .en_muldiv (MULDIV_EN),
            .instr     (out_instr[32*k +: 32]),
            .flags     (out_flags[8*k +: 8])
        );
    end
endmodule

// File: tb/tb_riscv_decode_queue.sv
// Scoreboard bench for riscv_decode_queue: directed scenarios plus random traffic against a queue model.
module tb_riscv_decode_queue;
    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam logic [6:0] OPS [12] = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h6f, 7'h67,
                                        7'h63, 7'h03, 7'h23, 7'h73, 7'h0f, 7'h33};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid, in_fault_fetch, in_fault_page, out_accept;
    logic [63:0] in_instr, in_pc;
    logic        in_accept, squash;
    logic [1:0]  out_valid, out_fault_fetch, out_fault_page;
    logic [63:0] out_instr, out_pc;
    logic [15:0] out_flags;
    logic [2:0]  occupancy;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ff;
        logic        fp;
    } ent_t;

    ent_t sb[$];
    ent_t pend[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    riscv_decode_queue #(.LANES(LANES), .DEPTH(DEPTH), .SUPPORT_MULDIV(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_fault_fetch(in_fault_fetch), .in_fault_page(in_fault_page),
        .in_accept(in_accept), .squash(squash),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_fault_fetch(out_fault_fetch), .out_fault_page(out_fault_page),
        .out_flags(out_flags), .out_accept(out_accept), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Flag meaning taken from the instruction class: which units it needs and whether it writes rd.
    function automatic logic [7:0] ref_flags(input logic [31:0] i);
        logic [6:0] op;
        logic wr, csr, dv, ml, br, ls, ex, bad;
        op = i[6:0];
        {wr, csr, dv, ml, br, ls, ex, bad} = 8'h00;
        if (op == 7'h37 || op == 7'h17 || op == 7'h13) begin
            ex = 1'b1; wr = 1'b1;
        end else if (op == 7'h33) begin
            if (i[31:25] == 7'h01) begin
                wr = 1'b1;
                if (i[14]) dv = 1'b1; else ml = 1'b1;
            end else if (i[31:25] == 7'h00 || i[31:25] == 7'h20) begin
                ex = 1'b1; wr = 1'b1;
            end else bad = 1'b1;
        end else if (op == 7'h6f || op == 7'h67) begin
            br = 1'b1; wr = 1'b1;
        end else if (op == 7'h63) br = 1'b1;
        else if (op == 7'h03) begin
            ls = 1'b1; wr = 1'b1;
        end else if (op == 7'h23) ls = 1'b1;
        else if (op == 7'h73) begin
            if (i[14:12] != 3'b000) begin
                csr = 1'b1; wr = 1'b1;
            end else ex = 1'b1;
        end else if (op == 7'h0f) ex = 1'b1;
        else bad = 1'b1;
        if (bad) return 8'h80;
        return {1'b0, wr, csr, dv, ml, br, ls, ex};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int s;
        r = $urandom;
        s = $urandom_range(0, 13);
        if (s < 12) r[6:0] = OPS[s];
        if (r[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h01;
                2: r[31:25] = 7'h20;
                default: r[31:25] = r[31:25];
            endcase
        end
        return r;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] fp,
                         input logic [1:0] ff, input logic [1:0] acc, input logic sq);
        ent_t e;
        @(posedge clk);
        #1;
        in_valid = v; in_instr = {i1, i0}; in_pc = {p1, p0};
        in_fault_page = fp; in_fault_fetch = ff; out_accept = acc; squash = sq;
        pend.delete();
        if (mon_en && !sq && sb.size() <= DEPTH - LANES) begin
            for (int k = 0; k < LANES; k++) begin
                if (!v[k]) break;
                e.pc    = k ? p1 : p0;
                e.ff    = ff[k];
                e.fp    = fp[k];
                e.instr = (ff[k] | fp[k]) ? 32'h0 : (k ? i1 : i0);
                pend.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic [1:0] acc);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, acc, 1'b0);
    endtask

    task automatic reset_checks();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_accept", in_accept, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_flags", out_flags, 0);
    endtask

    // Monitor: compare presented lanes with the model, then retire pops and admit pending pushes.
    always @(negedge clk) begin
        ent_t vis[$];
        bit   byp;
        int   nexp, popn;
        if (mon_en) begin
            byp = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
            byp = (sb.size() == 0) && !squash;
`endif
            vis  = byp ? pend : sb;
            nexp = (vis.size() < LANES) ? vis.size() : LANES;
            chk("occupancy", occupancy, sb.size());
            chk("in_accept", in_accept, (!squash && sb.size() <= DEPTH - LANES));
            for (int k = 0; k < LANES; k++) begin
                chk($sformatf("out_valid[%0d]", k), out_valid[k], k < nexp);
                if (k < nexp) begin
                    chk($sformatf("out_pc[%0d]", k), out_pc[32*k +: 32], vis[k].pc);
                    chk($sformatf("out_instr[%0d]", k), out_instr[32*k +: 32], vis[k].instr);
                    chk($sformatf("out_fault_fetch[%0d]", k), out_fault_fetch[k], vis[k].ff);
                    chk($sformatf("out_fault_page[%0d]", k), out_fault_page[k], vis[k].fp);
                    chk($sformatf("out_flags[%0d]", k), out_flags[8*k +: 8],
                        (vis[k].ff | vis[k].fp) ? 8'h80 : ref_flags(vis[k].instr));
                end else begin
                    chk($sformatf("idle_flags[%0d]", k), out_flags[8*k +: 8], 8'h00);
                end
            end
            popn = 0;
            while (popn < nexp && out_accept[popn]) popn++;
            if (squash) begin
                sb.delete();
            end else if (byp) begin
                repeat (popn) void'(pend.pop_front());
                sb = pend;
            end else begin
                repeat (popn) void'(sb.pop_front());
                foreach (pend[i]) sb.push_back(pend[i]);
            end
            pend.delete();
        end
    end

    initial begin
        logic [31:0] pc;
        logic [1:0]  v, fp, ff;
        rst_n = 1'b1;
        in_valid = 2'b11; in_instr = '1; in_pc = '1;
        in_fault_fetch = 2'b00; in_fault_page = 2'b00; out_accept = 2'b11; squash = 1'b0;
        repeat (3) reset_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 2'b00; out_accept = 2'b00;
        mon_en = 1'b1;

        // Dual push of addi x1,x0,1 then hold.
        drive(2'b11, 32'h00100093, 32'h00100093, 32'h100, 32'h104, 2'b00, 2'b00, 2'b00, 1'b0);
        drive(2'b11, 32'h002081b3, 32'h0220c1b3, 32'h108, 32'h10c, 2'b00, 2'b00, 2'b00, 1'b0);
        idle(2'b00);
        idle(2'b01);
        idle(2'b11);
        idle(2'b11);
        // Faulted lane is scrubbed.
        drive(2'b01, 32'hFFFFFFFF, 32'h0, 32'h200, 32'h0, 2'b01, 2'b00, 2'b00, 1'b0);
        drive(2'b11, 32'h00002083, 32'h00112023, 32'h204, 32'h208, 2'b00, 2'b10, 2'b00, 1'b0);
        idle(2'b11);
        idle(2'b11);
        // Squash with occupancy 3, concurrent push and pop.
        drive(2'b11, 32'h300022f3, 32'h00000073, 32'h300, 32'h304, 2'b00, 2'b00, 2'b00, 1'b0);
        drive(2'b01, 32'h000000b7, 32'h0, 32'h308, 32'h0, 2'b00, 2'b00, 2'b00, 1'b0);
        idle(2'b00);
        drive(2'b11, 32'h00100093, 32'h00100093, 32'hdead0, 32'hdead4, 2'b00, 2'b00, 2'b11, 1'b1);
        idle(2'b11);
        // Single-lane stream across pointer wrap.
        pc = 32'h1000;
        repeat (20) begin
            drive(2'b01, 32'h00100093, 32'h0, pc, 32'h0, 2'b00, 2'b00, 2'b01, 1'b0);
            pc = pc + 32'd4;
        end
        idle(2'b01);
        // Random traffic including gaps, non-thermometer accepts, faults and squashes.
        repeat (400) begin
            v  = 2'($urandom);
            fp = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            ff = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            drive(v, rand_instr(), rand_instr(), pc, pc + 32'd4, fp, ff, 2'($urandom),
                  $urandom_range(0, 19) == 0);
            pc = pc + 32'd8;
        end
        // Mid-operation reset drops everything.
        drive(2'b11, 32'h00100093, 32'h00100093, 32'h4000, 32'h4004, 2'b00, 2'b00, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b0;
        sb.delete();
        pend.delete();
        repeat (2) reset_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 2'b00; out_accept = 2'b00; squash = 1'b0;
        mon_en = 1'b1;
        repeat (60) begin
            drive(2'($urandom), rand_instr(), rand_instr(), pc, pc + 32'd4, 2'b00, 2'b00,
                  2'($urandom), 1'b0);
            pc = pc + 32'd8;
        end
        idle(2'b11);
        idle(2'b11);
        idle(2'b00);
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
